// File: rtl/if_stage_pkg.sv
// rtl/if_stage_pkg.sv - shared pipeline constants for the fetch stage
package if_stage_pkg;

  localparam logic [1:0] NPC_SEQ = 2'b00;
  localparam logic [1:0] NPC_BR  = 2'b01;
  localparam logic [1:0] NPC_J   = 2'b10;
  localparam logic [1:0] NPC_JR  = 2'b11;

  localparam logic [31:0] DEF_PC_RESET = 32'h0000_3000;
  localparam logic [31:0] DEF_IM_BASE  = 32'h0000_3000;
  localparam int          DEF_IM_AW    = 12;

endpackage

// File: rtl/if_stage_npc_calc.sv
// rtl/if_stage_npc_calc.sv - next-PC selection for sequential, branch, j/jal and jr
module npc_calc
  import if_stage_pkg::*;
(
  input  logic [31:0] i_pc_f,
  input  logic [31:0] i_pc_d,
  input  logic [1:0]  i_npc_sel,
  input  logic        i_branch_taken,
  input  logic [15:0] i_imm16,
  input  logic [25:0] i_instr_index,
  input  logic [31:0] i_rs_data,
  output logic [31:0] o_npc
);

  logic [31:0] w_pc_f4;
  logic [31:0] w_pc_d4;
  logic [31:0] w_br_off;

  // Targets are relative to the delay-slot address (branch PC + 4)
  assign w_pc_f4  = i_pc_f + 32'd4;
  assign w_pc_d4  = i_pc_d + 32'd4;
  assign w_br_off = {{14{i_imm16[15]}}, i_imm16, 2'b00};

  always_comb begin
    o_npc = w_pc_f4;
    case (i_npc_sel)
      NPC_SEQ: o_npc = w_pc_f4;
      NPC_BR:  o_npc = i_branch_taken ? (w_pc_d4 + w_br_off) : w_pc_f4;
      NPC_J:   o_npc = {w_pc_d4[31:28], i_instr_index, 2'b00};
      NPC_JR:  o_npc = i_rs_data;
      default: o_npc = w_pc_f4;
    endcase
  end

endmodule

// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction fetch stage with PC and IF/ID registers
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = DEF_PC_RESET,
  parameter logic [31:0] IM_BASE  = DEF_IM_BASE,
  parameter int          IM_AW    = DEF_IM_AW
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Stall,
  input  logic [1:0]       Npc_Sel,
  input  logic             Branch_Taken,
  input  logic [15:0]      Imm16_D,
  input  logic [25:0]      Instr_Index_D,
  input  logic [31:0]      Rs_Data_D,
  output logic [IM_AW-1:0] Im_Addr,
  input  logic [31:0]      Instr_F,
  output logic [31:0]      Pc_F,
  output logic [31:0]      Instr_D,
  output logic [31:0]      Pc_D,
  output logic [31:0]      Pc8_D,
  output logic             Exc_D
);

  localparam logic [32:0] IM_END = {1'b0, IM_BASE} + (33'd4 << IM_AW);

  logic [31:0] r_pc_f;
  logic [31:0] r_pc_d;
  logic [31:0] r_instr_d;
  logic        r_exc_d;
  logic [31:0] w_npc;
  logic        w_fetch_err;

  npc_calc u_npc_calc (
    .i_pc_f         (r_pc_f),
    .i_pc_d         (r_pc_d),
    .i_npc_sel      (Npc_Sel),
    .i_branch_taken (Branch_Taken),
    .i_imm16        (Imm16_D),
    .i_instr_index  (Instr_Index_D),
    .i_rs_data      (Rs_Data_D),
    .o_npc          (w_npc)
  );

  // 33-bit compare so a memory window ending at 2^32 cannot wrap
  assign w_fetch_err = (r_pc_f[1:0] != 2'b00) || (r_pc_f < IM_BASE) ||
                       ({1'b0, r_pc_f} >= IM_END);

  assign Im_Addr = IM_AW'((r_pc_f - IM_BASE) >> 2);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_pc_f    <= PC_RESET;
      r_pc_d    <= PC_RESET;
      r_instr_d <= 32'd0;
      r_exc_d   <= 1'b0;
    end else if (!Stall) begin
      r_pc_f    <= w_npc;
      r_pc_d    <= r_pc_f;
      r_instr_d <= w_fetch_err ? 32'd0 : Instr_F;
      r_exc_d   <= w_fetch_err;
    end
  end

  assign Pc_F    = r_pc_f;
  assign Pc_D    = r_pc_d;
  assign Instr_D = r_instr_d;
  assign Exc_D   = r_exc_d;
  assign Pc8_D   = r_pc_d + 32'd8;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage of the five-stage MIPS pipeline.
- Owns the PC register and drives the word address into the instruction memory. It takes the returned instruction and registers it into the IF/ID pipeline register.
- Next-PC is computed from ID-stage redirect requests (branch, j/jal, jr), with one architectural delay slot.
- Hazard-unit stall freezes both the PC and the IF/ID register.

Parameters:
- PC_RESET, 32'h0000_3000, PC value loaded on reset.
- IM_BASE, 32'h0000_3000, byte address mapped to instruction-memory word 0.
- IM_AW, 12, instruction-memory word-address width (4096 words).

Ports:
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high reset
- Stall  in  1  from hazard unit: hold PC and IF/ID this cycle
- Npc_Sel  in  2  00 sequential, 01 branch, 10 j/jal, 11 jr (decoded in ID)
- Branch_Taken  in  1  ID comparator result; only meaningful when Npc_Sel=01
- Imm16_D  in  16  branch offset field of the ID instruction
- Instr_Index_D  in  26  j/jal target field
- Rs_Data_D  in  32  forwarded rs value for jr
- Im_Addr  out  IM_AW  word address to instruction memory
- Instr_F  in  32  instruction returned combinationally by instruction memory
- Pc_F  out  32  current fetch PC
- Instr_D  out  32  IF/ID instruction
- Pc_D  out  32  IF/ID PC
- Pc8_D  out  32  Pc_D+8, link value for jal
- Exc_D  out  1  IF/ID fetch-address-error flag

Behaviour:
- Reset (async, any time, including mid-stall):
  - Pc_F=PC_RESET, Instr_D=0, Pc_D=PC_RESET, Exc_D=0.
  - Takes effect immediately, not at the next edge.
  - First edge after release latches the instruction at PC_RESET into ID.
- Im_Addr = (Pc_F − IM_BASE)[IM_AW+1:2], combinational, no latency. Instruction reaches ID one clock after its PC appears on Pc_F.
- Fetch error, combinational, evaluated on Pc_F. It is asserted if any of the following holds:
  - Pc_F[1:0]≠0
  - Pc_F<IM_BASE
  - Pc_F≥IM_BASE+4·2^IM_AW
  - When asserted: the IF/ID load writes Instr_D=0 (nop) and Exc_D=1. Otherwise Instr_D=Instr_F and Exc_D=0.
- Next PC (combinational):
  - Npc_Sel=00: Pc_F+4.
  - Npc_Sel=01, Branch_Taken=1: Pc_D+4+(sign_extend(Imm16_D)<<2).
  - Npc_Sel=01, Branch_Taken=0: Pc_F+4.
  - Npc_Sel=10: {Pc_D+4 [31:28], Instr_Index_D, 2'b00}.
  - Npc_Sel=11: Rs_Data_D (no alignment correction; a misaligned value triggers the fetch error above when it becomes Pc_F).
  - All adds are 32-bit modulo; wrap-around at 32'hFFFF_FFFC is not trapped here. An out-of-range PC is caught by the range check.
- Delay slot:
  - Redirect is computed while the branch/jump sits in ID. The instruction concurrently in IF (Pc_D+4) is the delay slot and enters ID normally on the same edge.
  - No flush path exists in this block.
- Clock edge, Stall=0: Pc_F<=NPC; Pc_D<=Pc_F; Instr_D/Exc_D loaded as above.
- Clock edge, Stall=1: Pc_F, Pc_D, Instr_D, Exc_D all hold.
  - Redirect inputs are ignored. The ID-stage instruction is also frozen, so it re-presents the same request on the first unstalled cycle.
- Pc8_D = Pc_D+8, combinational from the register.
- Reset dominates Stall.

Decomposition:
- Shared package (pipeline constants):
  - NPC_SEQ=2'b00, NPC_BR=2'b01, NPC_J=2'b10, NPC_JR=2'b11
  - PC_RESET and IM_BASE defaults, shared with the top level and the instruction memory
- One natural combinational sub-module, npc_calc: inputs Pc_F, Pc_D, Npc_Sel, Branch_Taken, Imm16_D, Instr_Index_D, Rs_Data_D; output Npc.
- Registers and error check stay in if_stage.

Test Plan:
- Reset held, then released; memory words 0..3 hold distinct values:
  - During reset: Pc_F=0x3000, Instr_D=0, Exc_D=0.
  - After edge 1: Pc_D=0x3000, Instr_D=word0, Pc_F=0x3004.
  - Sequential run continues: 0x3008, 0x300C.
- Stall=1 for 3 cycles at Pc_F=0x3008:
  - Pc_F, Pc_D and Instr_D are unchanged throughout.
  - Fetch resumes at 0x300C after release.
- beq at Pc_D=0x3010, Imm16_D=16'hFFFC:
  - Branch_Taken=1: next Pc_F=0x3004; the delay slot 0x3014 enters ID.
  - Branch_Taken=0: Pc_F=0x3018.
- jal at Pc_D=0x3020, Instr_Index_D=26'h0000C10:
  - Pc8_D=0x3028.
  - Next Pc_F=0x3040.
- jr with Rs_Data_D=0x3102:
  - Pc_F=0x3102.
  - Following edge: Instr_D=0, Exc_D=1.
  - Then jr 0x3000 recovers: Exc_D returns to 0.
- Reset asserted mid-clock during a stall with Pc_F=0x3400:
  - All outputs return to reset values immediately, before the next edge.
